// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: size codes, FSM states,
// byte-lane enable and misalignment helpers.
package dmem_pkg;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RDWAIT, RESP} state_t;

  typedef struct packed {
    logic [1:0] size;
    logic       sgn;
    logic [1:0] lo;
  } req_t;

  function automatic logic [NUM_LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << lo;
      SZ_HALF: lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: align_lo = lo;
      SZ_HALF: align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's data port (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [NUM_LANES-1:0][VEC_W-1:0] word,
  input  logic [1:0]                      lo,
  input  logic [1:0]                      size,
  input  logic                            sgn,
  output logic [31:0]                     rdata
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[lo];
  assign h = lo[1] ? word[3:2] : word[1:0];

  always_comb begin
    rdata = word;
    case (size)
      SZ_BYTE: rdata = {{24{sgn & b[7]}}, b};
      SZ_HALF: rdata = {{16{sgn & h[15]}}, h};
      default: rdata = word;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, owning a word RAM.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err instead of being aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  dmem_responder_if.slave bus
);
  localparam int WORDS = 1 << (ADDR_W - 2);
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic [NUM_LANES-1:0][VEC_W-1:0] mem [WORDS];
  logic [NUM_LANES-1:0][VEC_W-1:0] ram_q, wlanes;
  logic [NUM_LANES-1:0]            we_lanes;

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  req_t              rq;
  logic [ADDR_W-3:0] idx_q, idx_in;
  logic [1:0]        lo_in;
  logic              accept, is_mis;
  logic              valid_q, err_q;
  logic [31:0]       rdata_q, ext_data;
  logic              unused_addr;

  assign unused_addr   = ^bus.req_addr[31:ADDR_W];
  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign idx_in        = bus.req_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign is_mis       = misaligned(bus.req_size, bus.req_addr[1:0]);
  assign lo_in        = bus.req_addr[1:0];
  assign bus.resp_err = err_q;
`else
  assign is_mis       = 1'b0;
  assign lo_in        = align_lo(bus.req_size, bus.req_addr[1:0]);
  assign bus.resp_err = 1'b0;
`endif

  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;

  // Store data replicated across lanes so the lane enables alone pick the target bytes.
  assign we_lanes = lane_en(bus.req_size, lo_in);
  always_comb begin
    wlanes = bus.req_wdata;
    case (bus.req_size)
      SZ_BYTE: wlanes = {4{bus.req_wdata[7:0]}};
      SZ_HALF: wlanes = {2{bus.req_wdata[15:0]}};
      default: wlanes = bus.req_wdata;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (bus.req_we | is_mis) ? RESP : RDWAIT;
      RDWAIT:  if (cnt == CNT_W'(RD_LAT - 1)) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rq      <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= (nxt == RESP);
      cnt     <= (state == RDWAIT) ? cnt + 1'b1 : '0;
      if (accept) begin
        rq    <= '{size: bus.req_size, sgn: bus.req_signed, lo: lo_in};
        idx_q <= idx_in;
      end
      if (nxt == RESP) begin
        rdata_q <= (state == RDWAIT) ? ext_data : 32'h0;
        err_q   <= (state == IDLE) & is_mis;
      end
    end
  end

  // RAM kept free of reset so it maps to block memory; the read port re-reads the
  // latched word every cycle, so ram_q is current whenever RDWAIT ends.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !is_mis && !rst)
      for (int l = 0; l < NUM_LANES; l++)
        if (we_lanes[l]) mem[idx_in][l] <= wlanes[l];
    ram_q <= mem[accept ? idx_in : idx_q];
  end

  dmem_load_ext u_ext (
    .word  (ram_q),
    .lo    (rq.lo),
    .size  (rq.size),
    .sgn   (rq.sgn),
    .rdata (ext_data)
  );
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the MIPS core's data-memory port. It accepts one load or store request at a time through a valid/ready handshake and performs byte, half and word stores with lane enables. Loads complete with lane extraction and sign- or zero-extension. It owns an inferred single-port word RAM and replaces the raw RAM hookup at the top level, so the core can stall on resp_valid.

Parameters:
ADDR_W, 10, byte-address width; the RAM holds 2^(ADDR_W-2) 32-bit words.
RD_LAT, 1, RAM read latency in cycles (>=1); the wait-state counter width derives from it.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present; held stable until accepted
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_signed  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
req_addr  input  32  byte address; only [ADDR_W-1:0] is used
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse marking completion
resp_rdata  output  32  load result, valid with resp_valid; 0 for stores
resp_err  output  1  misaligned access, valid with resp_valid

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- FSM states: IDLE, RDWAIT, RESP.
- req_ready = 1 only in IDLE; it is a combinational decode of state.
- A request is accepted on a rising edge where req_valid & req_ready. The responder latches size, signed, addr[1:0] and word index addr[ADDR_W-1:2].
- Store: RAM bytes are committed on the accept edge. Next state is RESP. resp_valid rises 1 cycle after accept with resp_rdata = 0.
- Store lanes: SB writes wdata[7:0] to lane addr[1:0]. SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}. SW writes all 4 lanes. Lanes that are not enabled keep their contents.
- Load: next state is RDWAIT. A counter runs RD_LAT cycles, then the FSM enters RESP. resp_valid is asserted RD_LAT+1 cycles after accept.
- Load extraction: byte or half taken from the lane chosen by the latched addr bits, then sign- or zero-extended per the latched req_signed. Word loads ignore req_signed.
- RESP lasts exactly 1 cycle, then returns to IDLE. A new request can be accepted the cycle after the RESP pulse, so the maximum rate is one store every 2 cycles.
- resp_rdata and resp_err are registered and hold their value until the next RESP.
- Address bits above ADDR_W-1 are ignored, so addresses alias (wrap).
- Reset: state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0. RAM contents are not cleared.
- rst has priority over an accept in the same cycle: no RAM write occurs.
- Reset during RDWAIT or RESP aborts the access; no resp_valid is produced afterwards.
- req_valid arriving outside IDLE is ignored; the initiator must keep holding it.

Optional Feature:
DMEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is treated as misaligned. No RAM write or read occurs, the FSM goes directly to RESP, and resp_err=1 with resp_rdata=0 one cycle after accept.
- Undefined: the low address bits are forced aligned (addr[0] cleared for half accesses, addr[1:0] cleared for word accesses), the access proceeds normally, and resp_err is constant 0.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum (IDLE, RDWAIT, RESP);
  - function computing the 4-bit lane enable from size and addr[1:0].
- One sub-module, dmem_load_ext: combinational lane select plus sign/zero extension (32-bit word, addr[1:0], size, signed in; 32-bit result out). It is unit-testable on its own.

Test Plan:
- Store and reload word: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> resp_rdata = 0xDEADBEEF, RD_LAT+1 cycles after accept; store resp_valid 1 cycle after accept.
- Byte lanes: SW 0 to 0x20, then SB 0x7F to 0x23 and SB 0x80 to 0x21 -> LW 0x20 = 0x7F008000, LB 0x21 = 0xFFFFFF80, LBU 0x21 = 0x00000080.
- Halves: SH 0x8001 to 0x32 over word 0x11223344 at 0x30 -> LW = 0x80013344, LH 0x32 = 0xFFFF8001, LHU 0x32 = 0x00008001.
- Handshake: hold req_valid continuously with back-to-back loads -> req_ready low from accept until the RESP pulse; each resp_valid is exactly 1 cycle wide; no request is lost or duplicated.
- Reset mid-read: rst asserted for 1 cycle during RDWAIT -> no resp_valid afterwards, req_ready = 1 on the next cycle, outputs = 0.
- Misaligned SW to 0x41 -> with DMEM_MISALIGN_TRAP_EN: resp_err = 1 and word 0x40 unchanged; without it: the write lands at 0x40 and resp_err = 0.
